ex_stage: RTL and testbench
===========================

// Module: ex_stage
// PURPOSE
//  Execute stage; directly downstream of decode. Registers the ID->EX bus and runs the 12-op ALU on selected operands.
//  Owns the HI/LO registers and a 32-cycle iterative divider (div/divu), which holds the pipeline via stallreq.
//  Drives data SRAM requests, the EX->MEM bus and the EX forwarding triple back to decode.
// PARAMETERS
//  ID_TO_EX_WD   159  ID->EX bus: pc[158:127] inst[126:95] alu_op[94:83] src1[82:80] src2[79:76] ram_en[75] ram_wen[74:71] rf_we[70] rf_waddr[69:65] sel_rf_res[64] rs_val[63:32] rt_val[31:0]
//  EX_TO_MEM_WD  76   {pc[75:44], ram_en[43], ram_wen[42:39], sel_rf_res[38], rf_we[37], rf_waddr[36:32], result[31:0]}
//  STALL_W       6    stall vector width; bit2 = ID, bit3 = EX
// PORTS
//  clk               in   1    clock
//  rst               in   1    reset, synchronous, active-high
//  stall             in   6    per-stage stop (1 = stop)
//  id_to_ex_bus      in   159  decoded instruction + operands
//  ex_to_mem_bus     out  76   to MEM pipeline register
//  ex_write_en       out  1    forward: rf_we of instruction in EX
//  ex_write_address  out  5    forward: rf_waddr
//  ex_write_data     out  32   forward: ex result
//  ex_is_load        out  1    EX holds a load (ID must insert a load-use stall)
//  stallreq          out  1    divider busy; freeze IF..EX
//  data_sram_en      out  1    data SRAM enable
//  data_sram_wen     out  4    byte write enables
//  data_sram_addr    out  32   = ALU result
//  data_sram_wdata   out  32   = rt_val
// BEHAVIOUR
//  - Pipe reg: rst -> 0; stall[2]=1 & stall[3]=0 -> 0 (bubble); stall[2]=0 -> capture; otherwise hold.
//  - src1: [0] rs_val, [1] pc, [2] {27'b0,sa}. src2: [0] rt_val, [1] sext(imm), [2] 32'd8, [3] zext(imm).
//  - alu_op (MSB first) add,sub,slt,sltu,and,nor,or,xor,sll,srl,sra,lui: one-hot, AND-OR muxed, result mod 2^32.
//    Shifts use src1[4:0] as amount on src2. lui = {src2[15:0],16'b0}. slt signed, sltu unsigned.
//  - EX decodes inst[31:26]=0 with func: mfhi 010000, mthi 010001, mflo 010010, mtlo 010011, div 011010, divu 011011.
//  - result = HI (mfhi) | LO (mflo) | ALU output (all other instructions).
//  - mthi/mtlo: write rs_val at the cycle end when EX is not stalled; a following mfhi/mflo sees the new value.
//  - Combinational outputs (ex_to_mem_bus, forward triple, sram_*) are all 0 while the pipe reg is 0.
//    data_sram_en = ram_en & ~stall[3]; data_sram_wen = ram_wen & {4{data_sram_en}}.
//  - ex_is_load = ram_en & sel_rf_res.
//  - Divider FSM: IDLE -> RUN (32 iterations, restoring, 1 bit/cycle) -> DONE -> IDLE.
//    - IDLE with div/divu in EX: latch |rs|,|rt| and sign flags, counter = 0, go to RUN.
//    - RUN: counter increments each cycle; at count 31 go to DONE.
//    - DONE: write HI = remainder, LO = quotient, go to IDLE.
//    - stallreq = 1 in IDLE-with-div, RUN and DONE-pending: div enters EX at cycle N, stallreq is high N..N+32, the instruction leaves EX at N+33.
//    - DONE drops stallreq combinationally; the pipe reg must not restart the same div (FSM tracks a done flag, cleared on capture).
//    - Signs: quotient negative iff signs differ; remainder takes the dividend sign (div only).
//    - Divide by zero: LO = 0xFFFFFFFF, HI = dividend; no trap.
//    - 0x80000000 / -1 (div): LO = 0x80000000, HI = 0.
//  - rst mid-divide: FSM -> IDLE, counter 0, HI = LO = 0, stallreq = 0 next cycle.
//  - A bubble inserted by stall never writes HI/LO and never starts the divider.
// CONFIGURATION
//  EX_MULT_EN defined:
//    - mult (func 011000) and multu (011001) are decoded.
//    - 64-bit product written at the cycle end: {HI,LO}; single cycle, no stallreq.
//  EX_MULT_EN undefined:
//    - mult/multu are NOPs: no HI/LO write, rf_we passes through unchanged (0 from decode).
// TESTING
//  1. addiu rs_val=5, imm=0xFFFF (alu add, src1 rs, src2 sext) -> result 4, ex_write_en=1, forward data 4 same cycle.
//  2. sll sa=4, rt_val=0x0000_0001 -> result 0x10; sra with rt_val=0x8000_0000, amount 31 -> 0xFFFF_FFFF.
//  3. div rs=-7, rt=2 -> stallreq high 33 cycles; then LO=0xFFFF_FFFD, HI=0xFFFF_FFFF; mflo next -> 0xFFFF_FFFD.
//  4. divu rs=10, rt=0 -> LO=0xFFFF_FFFF, HI=10; rst asserted at iteration 15 of another div -> stallreq 0, HI=LO=0.
//  5. lw in EX with stall[3]=1 -> data_sram_en=0, ex_is_load=1; release -> data_sram_en=1, addr = rs+sext(imm).
//  6. EX_MULT_EN: mult 0xFFFF_FFFF x 2 -> HI=0xFFFF_FFFF, LO=0xFFFF_FFFE; undefined -> HI/LO unchanged.

Source files
------------

// File: rtl/ex_stage.sv
// Execute stage: ID->EX pipe register, 12-op ALU, HI/LO, 32-cycle restoring divider.
// Define EX_MULT_EN to decode mult/multu as single-cycle writes of {HI,LO}.
module ex_stage #(
  parameter int unsigned ID_TO_EX_WD  = 159,
  parameter int unsigned EX_TO_MEM_WD = 76,
  parameter int unsigned STALL_W      = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [STALL_W-1:0]      stall,
  input  logic [ID_TO_EX_WD-1:0]  id_to_ex_bus,
  output logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
  output logic                    ex_write_en,
  output logic [4:0]              ex_write_address,
  output logic [31:0]             ex_write_data,
  output logic                    ex_is_load,
  output logic                    stallreq,
  output logic                    data_sram_en,
  output logic [3:0]              data_sram_wen,
  output logic [31:0]             data_sram_addr,
  output logic [31:0]             data_sram_wdata
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} div_state_e;

  logic [ID_TO_EX_WD-1:0] id_to_ex_q;
  logic                   pipe_advance;

  assign pipe_advance = ~(stall[2] & stall[3]);

  always_ff @(posedge clk) begin
    if (rst) begin
      id_to_ex_q <= '0;
    end else if (stall[2] && !stall[3]) begin
      id_to_ex_q <= '0;
    end else if (!stall[2]) begin
      id_to_ex_q <= id_to_ex_bus;
    end
  end

  logic [31:0] pc, inst, rs_val, rt_val;
  logic [11:0] alu_op;
  logic [2:0]  src1_sel;
  logic [3:0]  src2_sel, ram_wen;
  logic        ram_en, rf_we, sel_rf_res;
  logic [4:0]  rf_waddr;

  assign pc         = id_to_ex_q[158:127];
  assign inst       = id_to_ex_q[126:95];
  assign alu_op     = id_to_ex_q[94:83];
  assign src1_sel   = id_to_ex_q[82:80];
  assign src2_sel   = id_to_ex_q[79:76];
  assign ram_en     = id_to_ex_q[75];
  assign ram_wen    = id_to_ex_q[74:71];
  assign rf_we      = id_to_ex_q[70];
  assign rf_waddr   = id_to_ex_q[69:65];
  assign sel_rf_res = id_to_ex_q[64];
  assign rs_val     = id_to_ex_q[63:32];
  assign rt_val     = id_to_ex_q[31:0];

  logic unused_bits;
  assign unused_bits = ^{inst[25:16], stall[STALL_W-1:4], stall[1:0]};

  // ALU
  logic [31:0] src1, src2, alu_res;
  logic [31:0] add_res, sub_res, slt_res, sltu_res, sll_res, srl_res, sra_res, lui_res;

  assign src1 = ({32{src1_sel[0]}} & rs_val)
              | ({32{src1_sel[1]}} & pc)
              | ({32{src1_sel[2]}} & {27'b0, inst[10:6]});
  assign src2 = ({32{src2_sel[0]}} & rt_val)
              | ({32{src2_sel[1]}} & {{16{inst[15]}}, inst[15:0]})
              | ({32{src2_sel[2]}} & 32'd8)
              | ({32{src2_sel[3]}} & {16'b0, inst[15:0]});

  assign add_res  = src1 + src2;
  assign sub_res  = src1 - src2;
  assign slt_res  = {31'b0, $signed(src1) < $signed(src2)};
  assign sltu_res = {31'b0, src1 < src2};
  assign sll_res  = src2 << src1[4:0];
  assign srl_res  = src2 >> src1[4:0];
  assign sra_res  = $unsigned($signed(src2) >>> src1[4:0]);
  assign lui_res  = {src2[15:0], 16'b0};

  assign alu_res = ({32{alu_op[11]}} & add_res)
                 | ({32{alu_op[10]}} & sub_res)
                 | ({32{alu_op[9]}}  & slt_res)
                 | ({32{alu_op[8]}}  & sltu_res)
                 | ({32{alu_op[7]}}  & (src1 & src2))
                 | ({32{alu_op[6]}}  & ~(src1 | src2))
                 | ({32{alu_op[5]}}  & (src1 | src2))
                 | ({32{alu_op[4]}}  & (src1 ^ src2))
                 | ({32{alu_op[3]}}  & sll_res)
                 | ({32{alu_op[2]}}  & srl_res)
                 | ({32{alu_op[1]}}  & sra_res)
                 | ({32{alu_op[0]}}  & lui_res);

  // HI/LO instruction decode
  logic special, inst_mfhi, inst_mthi, inst_mflo, inst_mtlo, inst_div, inst_divu;
  assign special   = (inst[31:26] == 6'b000000);
  assign inst_mfhi = special & (inst[5:0] == 6'b010000);
  assign inst_mthi = special & (inst[5:0] == 6'b010001);
  assign inst_mflo = special & (inst[5:0] == 6'b010010);
  assign inst_mtlo = special & (inst[5:0] == 6'b010011);
  assign inst_div  = special & (inst[5:0] == 6'b011010);
  assign inst_divu = special & (inst[5:0] == 6'b011011);

  // Divider
  div_state_e  div_state_q, div_state_d;
  logic [4:0]  div_cnt_q, div_cnt_d;
  logic [31:0] div_rem_q, div_rem_d, div_quo_q, div_quo_d, div_dvs_q, div_dvs_d;
  logic [31:0] div_dvd_q, div_dvd_d;
  logic        div_qneg_q, div_qneg_d, div_rneg_q, div_rneg_d;
  logic        div_zero_q, div_zero_d, div_done_q, div_done_d;
  logic        div_start, div_wr;
  logic [32:0] rem_shift, rem_trial;
  logic [31:0] quo_fix, rem_fix, div_hi, div_lo;

  // done flag keeps a held div from being restarted after its result is written
  assign div_start = (div_state_q == StIdle) & (inst_div | inst_divu) & ~div_done_q;
  assign stallreq  = div_start | (div_state_q == StRun);
  assign rem_shift = {div_rem_q, div_quo_q[31]};
  assign rem_trial = rem_shift - {1'b0, div_dvs_q};

  always_comb begin
    div_state_d = div_state_q;
    div_cnt_d   = div_cnt_q;
    div_rem_d   = div_rem_q;
    div_quo_d   = div_quo_q;
    div_dvs_d   = div_dvs_q;
    div_dvd_d   = div_dvd_q;
    div_qneg_d  = div_qneg_q;
    div_rneg_d  = div_rneg_q;
    div_zero_d  = div_zero_q;
    div_done_d  = pipe_advance ? 1'b0 : div_done_q;
    div_wr      = 1'b0;
    unique case (div_state_q)
      StIdle: begin
        if (div_start) begin
          div_quo_d   = (inst_div & rs_val[31]) ? (32'd0 - rs_val) : rs_val;
          div_dvs_d   = (inst_div & rt_val[31]) ? (32'd0 - rt_val) : rt_val;
          div_rem_d   = '0;
          div_cnt_d   = '0;
          div_dvd_d   = rs_val;
          div_qneg_d  = inst_div & (rs_val[31] ^ rt_val[31]);
          div_rneg_d  = inst_div & rs_val[31];
          div_zero_d  = (rt_val == 32'd0);
          div_state_d = StRun;
        end
      end
      StRun: begin
        if (!rem_trial[32]) begin
          div_rem_d = rem_trial[31:0];
          div_quo_d = {div_quo_q[30:0], 1'b1};
        end else begin
          div_rem_d = rem_shift[31:0];
          div_quo_d = {div_quo_q[30:0], 1'b0};
        end
        div_cnt_d = div_cnt_q + 5'd1;
        if (div_cnt_q == 5'd31) div_state_d = StDone;
      end
      StDone: begin
        div_wr      = 1'b1;
        div_state_d = StIdle;
        if (!pipe_advance) div_done_d = 1'b1;
      end
      default: div_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_state_q <= StIdle;
      div_cnt_q   <= '0;
      div_rem_q   <= '0;
      div_quo_q   <= '0;
      div_dvs_q   <= '0;
      div_dvd_q   <= '0;
      div_qneg_q  <= 1'b0;
      div_rneg_q  <= 1'b0;
      div_zero_q  <= 1'b0;
      div_done_q  <= 1'b0;
    end else begin
      div_state_q <= div_state_d;
      div_cnt_q   <= div_cnt_d;
      div_rem_q   <= div_rem_d;
      div_quo_q   <= div_quo_d;
      div_dvs_q   <= div_dvs_d;
      div_dvd_q   <= div_dvd_d;
      div_qneg_q  <= div_qneg_d;
      div_rneg_q  <= div_rneg_d;
      div_zero_q  <= div_zero_d;
      div_done_q  <= div_done_d;
    end
  end

  assign quo_fix = div_qneg_q ? (32'd0 - div_quo_q) : div_quo_q;
  assign rem_fix = div_rneg_q ? (32'd0 - div_rem_q) : div_rem_q;
  assign div_lo  = div_zero_q ? 32'hFFFF_FFFF : quo_fix;
  assign div_hi  = div_zero_q ? div_dvd_q : rem_fix;

  // HI/LO
  logic [31:0] hi_q, hi_d, lo_q, lo_d;

`ifdef EX_MULT_EN
  logic        inst_mult, inst_multu;
  logic [63:0] mul_a, mul_b, product;
  assign inst_mult  = special & (inst[5:0] == 6'b011000);
  assign inst_multu = special & (inst[5:0] == 6'b011001);
  assign mul_a      = {(inst_mult ? {32{rs_val[31]}} : 32'b0), rs_val};
  assign mul_b      = {(inst_mult ? {32{rt_val[31]}} : 32'b0), rt_val};
  assign product    = mul_a * mul_b;
`endif

  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (div_wr) begin
      hi_d = div_hi;
      lo_d = div_lo;
    end else if (!stall[3]) begin
      if (inst_mthi) hi_d = rs_val;
      if (inst_mtlo) lo_d = rs_val;
`ifdef EX_MULT_EN
      if (inst_mult | inst_multu) begin
        hi_d = product[63:32];
        lo_d = product[31:0];
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  // Outputs
  logic [31:0] ex_result;

  always_comb begin
    ex_result = alu_res;
    if (inst_mfhi)      ex_result = hi_q;
    else if (inst_mflo) ex_result = lo_q;
  end

  assign ex_to_mem_bus    = {pc, ram_en, ram_wen, sel_rf_res, rf_we, rf_waddr, ex_result};
  assign ex_write_en      = rf_we;
  assign ex_write_address = rf_waddr;
  assign ex_write_data    = ex_result;
  assign ex_is_load       = ram_en & sel_rf_res;
  assign data_sram_en     = ram_en & ~stall[3];
  assign data_sram_wen    = ram_wen & {4{data_sram_en}};
  assign data_sram_addr   = alu_res;
  assign data_sram_wdata  = rt_val;

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: ALU, forwarding, SRAM gating, HI/LO, divider stalls and reset.
module tb_ex_stage;

  localparam logic [31:0] Pc     = 32'hBFC0_0100;
  localparam logic [11:0] OpAdd  = 12'b1000_0000_0000;
  localparam logic [11:0] OpSub  = 12'b0100_0000_0000;
  localparam logic [11:0] OpSlt  = 12'b0010_0000_0000;
  localparam logic [11:0] OpSltu = 12'b0001_0000_0000;
  localparam logic [11:0] OpNor  = 12'b0000_0100_0000;
  localparam logic [11:0] OpSll  = 12'b0000_0000_1000;
  localparam logic [11:0] OpSra  = 12'b0000_0000_0010;
  localparam logic [11:0] OpLui  = 12'b0000_0000_0001;
  localparam logic [31:0] IMfhi  = 32'h0000_0010;
  localparam logic [31:0] IMthi  = 32'h0000_0011;
  localparam logic [31:0] IMflo  = 32'h0000_0012;
  localparam logic [31:0] IMtlo  = 32'h0000_0013;
  localparam logic [31:0] IMult  = 32'h0000_0018;
  localparam logic [31:0] IDiv   = 32'h0000_001A;
  localparam logic [31:0] IDivu  = 32'h0000_001B;

  logic         clk = 1'b0;
  logic         rst;
  logic [5:0]   tb_stall;
  logic [5:0]   stall;
  logic [158:0] id_bus;
  logic [75:0]  ex_to_mem_bus;
  logic         ex_write_en, ex_is_load, stallreq, data_sram_en;
  logic [4:0]   ex_write_address;
  logic [31:0]  ex_write_data, data_sram_addr, data_sram_wdata;
  logic [3:0]   data_sram_wen;
  int           total = 0;
  int           bad = 0;
  int           n;

  always #5 clk = ~clk;

  // divider busy freezes IF..EX like the pipeline's stall controller
  assign stall = stallreq ? 6'b001111 : tb_stall;

  ex_stage dut (
    .clk              (clk),
    .rst              (rst),
    .stall            (stall),
    .id_to_ex_bus     (id_bus),
    .ex_to_mem_bus    (ex_to_mem_bus),
    .ex_write_en      (ex_write_en),
    .ex_write_address (ex_write_address),
    .ex_write_data    (ex_write_data),
    .ex_is_load       (ex_is_load),
    .stallreq         (stallreq),
    .data_sram_en     (data_sram_en),
    .data_sram_wen    (data_sram_wen),
    .data_sram_addr   (data_sram_addr),
    .data_sram_wdata  (data_sram_wdata)
  );

  function automatic logic [158:0] mk(input logic [31:0] inst, input logic [11:0] op,
                                      input logic [2:0] s1, input logic [3:0] s2,
                                      input logic ram_en, input logic [3:0] wen, input logic we,
                                      input logic [4:0] wa, input logic sel,
                                      input logic [31:0] rs, input logic [31:0] rt);
    return {Pc, inst, op, s1, s2, ram_en, wen, we, wa, sel, rs, rt};
  endfunction

  function automatic logic [158:0] hilo(input logic [31:0] inst, input logic [31:0] rs,
                                        input logic [31:0] rt);
    return mk(inst, 12'b0, 3'b001, 4'b0001, 1'b0, 4'h0, 1'b0, 5'd0, 1'b0, rs, rt);
  endfunction

  function automatic logic [158:0] rd_hilo(input logic [31:0] inst);
    return mk(inst, 12'b0, 3'b000, 4'b0000, 1'b0, 4'h0, 1'b1, 5'd8, 1'b0, 32'd0, 32'd0);
  endfunction

  task automatic check(input string tag, input logic [75:0] obs, input logic [75:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [158:0] b);
    id_bus = b;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_div(input string tag);
    n = 0;
    while (stallreq === 1'b1 && n < 200) begin
      n++;
      @(posedge clk);
      #1;
    end
    check(tag, n, 33);
  endtask

  initial begin
    rst = 1'b1;
    tb_stall = 6'b0;
    id_bus = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_bus", ex_to_mem_bus, 76'd0);
    check("rst_stallreq", stallreq, 1'b0);
    check("rst_sram_en", data_sram_en, 1'b0);
    check("rst_we", ex_write_en, 1'b0);
    rst = 1'b0;

    // addiu rs=5, imm=0xFFFF
    issue(mk(32'h2422_FFFF, OpAdd, 3'b001, 4'b0010, 1'b0, 4'h0, 1'b1, 5'd2, 1'b0, 32'd5, 32'd0));
    check("addiu_data", ex_write_data, 32'd4);
    check("addiu_we", ex_write_en, 1'b1);
    check("addiu_addr", ex_write_address, 5'd2);
    check("addiu_bus", ex_to_mem_bus, {Pc, 1'b0, 4'h0, 1'b0, 1'b1, 5'd2, 32'd4});

    // hold keeps the instruction; bubble clears it
    tb_stall = 6'b001100;
    issue(mk(32'h0, OpSub, 3'b001, 4'b0001, 1'b0, 4'h0, 1'b1, 5'd3, 1'b0, 32'd5, 32'd7));
    check("hold_data", ex_write_data, 32'd4);
    tb_stall = 6'b000100;
    issue(mk(32'h0, OpSub, 3'b001, 4'b0001, 1'b0, 4'h0, 1'b1, 5'd3, 1'b0, 32'd5, 32'd7));
    check("bubble_bus", ex_to_mem_bus, 76'd0);
    tb_stall = 6'b0;

    issue(mk(32'h0, OpSub, 3'b001, 4'b0001, 1'b0, 4'h0, 1'b1, 5'd3, 1'b0, 32'd5, 32'd7));
    check("sub", ex_write_data, 32'hFFFF_FFFE);
    issue(mk(32'h0003_2100, OpSll, 3'b100, 4'b0001, 1'b0, 4'h0, 1'b1, 5'd4, 1'b0, 32'd0, 32'd1));
    check("sll", ex_write_data, 32'h0000_0010);
    issue(mk(32'h0003_27C3, OpSra, 3'b100, 4'b0001, 1'b0, 4'h0, 1'b1, 5'd4, 1'b0, 32'd0,
             32'h8000_0000));
    check("sra", ex_write_data, 32'hFFFF_FFFF);
    issue(mk(32'h0, OpSlt, 3'b001, 4'b0001, 1'b0, 4'h0, 1'b1, 5'd4, 1'b0, 32'hFFFF_FFFF, 32'd1));
    check("slt", ex_write_data, 32'd1);
    issue(mk(32'h0, OpSltu, 3'b001, 4'b0001, 1'b0, 4'h0, 1'b1, 5'd4, 1'b0, 32'hFFFF_FFFF, 32'd1));
    check("sltu", ex_write_data, 32'd0);
    issue(mk(32'h0, OpNor, 3'b001, 4'b0001, 1'b0, 4'h0, 1'b1, 5'd4, 1'b0, 32'h0F0F_0000,
             32'h00F0_000F));
    check("nor", ex_write_data, 32'hF000_FFF0);
    issue(mk(32'h3C04_1234, OpLui, 3'b000, 4'b1000, 1'b0, 4'h0, 1'b1, 5'd4, 1'b0, 32'd0, 32'd0));
    check("lui", ex_write_data, 32'h1234_0000);
    issue(mk(32'h0C00_0000, OpAdd, 3'b010, 4'b0100, 1'b0, 4'h0, 1'b1, 5'd31, 1'b0, 32'd0, 32'd0));
    check("pc_plus8", ex_write_data, Pc + 32'd8);

    // lw with EX stalled, then released
    issue(mk(32'h8C22_FFFC, OpAdd, 3'b001, 4'b0010, 1'b1, 4'h0, 1'b1, 5'd2, 1'b1, 32'h1000,
             32'd0));
    tb_stall = 6'b001100;
    #1;
    check("lw_stalled_en", data_sram_en, 1'b0);
    check("lw_is_load", ex_is_load, 1'b1);
    tb_stall = 6'b0;
    #1;
    check("lw_en", data_sram_en, 1'b1);
    check("lw_addr", data_sram_addr, 32'h0000_0FFC);
    issue(mk(32'hAC22_0004, OpAdd, 3'b001, 4'b0010, 1'b1, 4'hF, 1'b0, 5'd0, 1'b0, 32'h2000,
             32'hDEAD_BEEF));
    check("sw_wen", data_sram_wen, 4'hF);
    check("sw_wdata", data_sram_wdata, 32'hDEAD_BEEF);
    check("sw_addr", data_sram_addr, 32'h0000_2004);
    check("sw_not_load", ex_is_load, 1'b0);

    // mthi/mtlo then read back
    issue(hilo(IMthi, 32'h1234_5678, 32'd0));
    issue(rd_hilo(IMfhi));
    check("mfhi", ex_write_data, 32'h1234_5678);
    issue(hilo(IMtlo, 32'hCAFE_F00D, 32'd0));
    issue(rd_hilo(IMflo));
    check("mflo", ex_write_data, 32'hCAFE_F00D);

    issue(hilo(IMult, 32'hFFFF_FFFF, 32'd2));
    check("mult_stallreq", stallreq, 1'b0);
    issue(rd_hilo(IMfhi));
`ifdef EX_MULT_EN
    check("mult_hi", ex_write_data, 32'hFFFF_FFFF);
`else
    check("mult_hi", ex_write_data, 32'h1234_5678);
`endif
    issue(rd_hilo(IMflo));
`ifdef EX_MULT_EN
    check("mult_lo", ex_write_data, 32'hFFFF_FFFE);
`else
    check("mult_lo", ex_write_data, 32'hCAFE_F00D);
`endif

    // div -7 / 2
    issue(hilo(IDiv, 32'hFFFF_FFF9, 32'd2));
    check("div_stallreq", stallreq, 1'b1);
    id_bus = rd_hilo(IMflo);
    wait_div("div_cycles");
    @(posedge clk);
    #1;
    check("div_lo", ex_write_data, 32'hFFFF_FFFD);
    check("div_released", stallreq, 1'b0);
    issue(rd_hilo(IMfhi));
    check("div_hi", ex_write_data, 32'hFFFF_FFFF);

    // divu 10 / 0, held in EX after completion: must not restart
    issue(hilo(IDivu, 32'd10, 32'd0));
    tb_stall = 6'b001100;
    id_bus = rd_hilo(IMfhi);
    wait_div("divu_cycles");
    @(posedge clk);
    #1;
    check("divu_no_restart1", stallreq, 1'b0);
    @(posedge clk);
    #1;
    check("divu_no_restart2", stallreq, 1'b0);
    tb_stall = 6'b0;
    @(posedge clk);
    #1;
    check("divu0_hi", ex_write_data, 32'd10);
    issue(rd_hilo(IMflo));
    check("divu0_lo", ex_write_data, 32'hFFFF_FFFF);

    // reset at iteration 15 of a divide
    issue(hilo(IDiv, 32'd100, 32'd3));
    id_bus = rd_hilo(IMfhi);
    repeat (16) @(posedge clk);
    #1;
    check("mid_div_busy", stallreq, 1'b1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_div_stallreq", stallreq, 1'b0);
    rst = 1'b0;
    issue(rd_hilo(IMfhi));
    check("rst_hi", ex_write_data, 32'd0);
    issue(rd_hilo(IMflo));
    check("rst_lo", ex_write_data, 32'd0);

    // 0x80000000 / -1
    issue(hilo(IDiv, 32'h8000_0000, 32'hFFFF_FFFF));
    id_bus = rd_hilo(IMflo);
    wait_div("ovf_cycles");
    @(posedge clk);
    #1;
    check("ovf_lo", ex_write_data, 32'h8000_0000);
    issue(hilo(IMthi, 32'h5555_5555, 32'd0));
    issue(rd_hilo(IMfhi));
    check("mthi_after_div", ex_write_data, 32'h5555_5555);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
